// File: rtl/branch_check_pkg.sv
// Shared definitions for the branch-check block.
//   PC_W        : default program-counter width
//   bc_state_t  : checker FSM states (RUN, FLUSH)
//   clog2()     : ceiling log2, used to size queue pointers
package branch_check_pkg;

  localparam int PC_W = 32;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } bc_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/branch_check_pred_fifo.sv
// Generic DEPTH x WIDTH circular buffer holding in-order predictions.
//   clk, rst        : clock, asynchronous active-high reset
//   push_i, wdata_i : append an entry (caller guarantees room, or a same-cycle pop)
//   pop_i           : retire the oldest entry (caller guarantees non-empty)
//   flush_i         : discard everything left after this cycle's pop
//   rdata_o         : oldest entry
//   count_o         : occupancy, 0..DEPTH
//   full_o, empty_o : occupancy flags
module pred_fifo
  import branch_check_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  input  logic [WIDTH-1:0]        wdata_i,
  output logic [WIDTH-1:0]        rdata_o,
  output logic [clog2(DEPTH):0]   count_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    // Pointers are exactly log2(DEPTH) bits, so +1 wraps modulo DEPTH.
    if (pop_i) rptr_d = rptr_q + 1'b1;
    if (flush_i) begin
      // Everything younger than the popped entry is wrong-path.
      wptr_d  = rptr_d;
      count_d = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/branch_check.sv
// Branch-prediction checker between fetch/predict and execute.
// Queues predicted next-PCs in order, compares each with the actual next-PC
// when execute resolves it, and emits one-cycle pulses for the CSR counters.
// A mismatch flushes younger predictions and redirects fetch.
//   clk, rst                  : clock, asynchronous active-high reset
//   predPush, predNextPc      : prediction pushed by fetch
//   predReady                 : queue has room and checker is in RUN
//   resValid, resNextPc       : resolution of the oldest control transfer
//   isControlxfer             : pulse per accepted resolution
//   wrongBranch               : pulse when the resolution mismatched
//   redirectValid, redirectPc : fetch restart request (PC held between pulses)
//   qEmpty                    : no outstanding predictions
//   errOverflow, errUnderflow : sticky misuse flags, cleared only by reset
module branch_check
  import branch_check_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = PC_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            predPush,
  input  logic [XLEN-1:0] predNextPc,
  output logic            predReady,
  input  logic            resValid,
  input  logic [XLEN-1:0] resNextPc,
  output logic            isControlxfer,
  output logic            wrongBranch,
  output logic            redirectValid,
  output logic [XLEN-1:0] redirectPc,
  output logic            qEmpty,
  output logic            errOverflow,
  output logic            errUnderflow
);

  localparam int CNT_W = clog2(DEPTH) + 1;

  bc_state_t        state_q, state_d;
  logic [XLEN-1:0]  head_pc;
  logic [CNT_W-1:0] count;
  logic             full, empty;
  logic             run;
  logic             pop, mismatch, push_acc, of_set, uf_set;

  logic             ctl_q, wrong_q, redir_q;
  logic [XLEN-1:0]  redir_pc_q, redir_pc_d;
  logic             of_q, uf_q;

  assign run      = (state_q == RUN);
  assign pop      = run && resValid && !empty;
  assign mismatch = pop && (head_pc != resNextPc);
  // A pop frees a slot in the same cycle, so push-while-full is legal then.
  // A push alongside a mismatch is wrong-path and silently dropped.
  assign push_acc = run && predPush && !mismatch && (!full || pop);
  assign of_set   = run && predPush && full && !pop;
  assign uf_set   = run && resValid && empty;

  pred_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_acc),
    .pop_i   (pop),
    .flush_i (mismatch),
    .wdata_i (predNextPc),
    .rdata_o (head_pc),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (mismatch) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    redir_pc_d = redir_pc_q;
    if (mismatch) redir_pc_d = resNextPc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      ctl_q      <= 1'b0;
      wrong_q    <= 1'b0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
      of_q       <= 1'b0;
      uf_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctl_q      <= pop;
      wrong_q    <= mismatch;
      redir_q    <= mismatch;
      redir_pc_q <= redir_pc_d;
      of_q       <= of_q | of_set;
      uf_q       <= uf_q | uf_set;
    end
  end

  assign predReady     = (count < CNT_W'(DEPTH)) && run;
  assign qEmpty        = (count == '0);
  assign isControlxfer = ctl_q;
  assign wrongBranch   = wrong_q;
  assign redirectValid = redir_q;
  assign redirectPc    = redir_pc_q;
  assign errOverflow   = of_q;
  assign errUnderflow  = uf_q;

endmodule

// File: tb/tb_branch_check.sv
module tb_branch_check;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk;
  logic            rst;
  logic            predPush;
  logic [XLEN-1:0] predNextPc;
  logic            predReady;
  logic            resValid;
  logic [XLEN-1:0] resNextPc;
  logic            isControlxfer;
  logic            wrongBranch;
  logic            redirectValid;
  logic [XLEN-1:0] redirectPc;
  logic            qEmpty;
  logic            errOverflow;
  logic            errUnderflow;

  branch_check #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk           (clk),
    .rst           (rst),
    .predPush      (predPush),
    .predNextPc    (predNextPc),
    .predReady     (predReady),
    .resValid      (resValid),
    .resNextPc     (resNextPc),
    .isControlxfer (isControlxfer),
    .wrongBranch   (wrongBranch),
    .redirectValid (redirectValid),
    .redirectPc    (redirectPc),
    .qEmpty        (qEmpty),
    .errOverflow   (errOverflow),
    .errUnderflow  (errUnderflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a queue of outstanding predictions plus flags.
  logic [XLEN-1:0] mq[$];
  bit              m_flush;
  bit              m_of, m_uf;
  bit              e_ctl, e_wrong;
  logic [XLEN-1:0] e_rpc;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_flush = 0; m_of = 0; m_uf = 0;
    e_ctl = 0; e_wrong = 0; e_rpc = '0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ctl"},   {31'b0, isControlxfer}, {31'b0, e_ctl});
    chk({tag, ".wrong"}, {31'b0, wrongBranch},   {31'b0, e_wrong});
    chk({tag, ".rdv"},   {31'b0, redirectValid}, {31'b0, e_wrong});
    chk({tag, ".rpc"},   redirectPc,             e_rpc);
    chk({tag, ".empty"}, {31'b0, qEmpty},        {31'b0, (mq.size() == 0)});
    chk({tag, ".ready"}, {31'b0, predReady},     {31'b0, (mq.size() < DEPTH) && !m_flush});
    chk({tag, ".of"},    {31'b0, errOverflow},   {31'b0, m_of});
    chk({tag, ".uf"},    {31'b0, errUnderflow},  {31'b0, m_uf});
  endtask

  // One clock cycle: drive inputs, advance the model, check after the edge.
  task automatic cycle(input bit p, input logic [XLEN-1:0] pd,
                       input bit r, input logic [XLEN-1:0] rd, input string tag);
    logic [XLEN-1:0] front;
    bit mis;
    predPush = p; predNextPc = pd; resValid = r; resNextPc = rd;
    mis = 0; e_ctl = 0;
    if (m_flush) begin
      m_flush = 0;
    end else begin
      if (r) begin
        if (mq.size() == 0) m_uf = 1;
        else begin
          front = mq.pop_front();
          e_ctl = 1;
          if (front != rd) mis = 1;
        end
      end
      if (p && !mis) begin
        if (mq.size() < DEPTH) mq.push_back(pd);
        else m_of = 1;
      end
      if (mis) begin
        mq.delete();
        m_flush = 1;
        e_rpc = rd;
      end
    end
    e_wrong = mis;
    @(posedge clk);
    #1;
    predPush = 0; resValid = 0;
    check_all(tag);
  endtask

  initial begin
    logic [XLEN-1:0] v;
    bit p, r;
    predPush = 0; predNextPc = '0; resValid = 0; resNextPc = '0;
    model_reset();
    rst = 1'b1;
    #12;
    check_all("reset");
    rst = 1'b0;
    #4;

    // Two matching resolutions.
    cycle(1, 32'h100, 0, 0, "m.push1");
    cycle(1, 32'h200, 0, 0, "m.push2");
    cycle(0, 0, 1, 32'h100, "m.res1");
    chk("m.res1.pulse", {31'b0, isControlxfer}, 32'd1);
    cycle(0, 0, 1, 32'h200, "m.res2");
    cycle(0, 0, 0, 0, "m.idle");
    chk("m.end.empty", {31'b0, qEmpty}, 32'd1);

    // Mismatch, then push during FLUSH is ignored.
    cycle(1, 32'h100, 0, 0, "x.push1");
    cycle(1, 32'h200, 0, 0, "x.push2");
    cycle(1, 32'h300, 0, 0, "x.push3");
    cycle(0, 0, 1, 32'h104, "x.res");
    chk("x.rpc", redirectPc, 32'h104);
    chk("x.flush.ready", {31'b0, predReady}, 32'd0);
    cycle(1, 32'h500, 0, 0, "x.flushpush");
    cycle(0, 0, 0, 0, "x.run");
    chk("x.run.ready", {31'b0, predReady}, 32'd1);

    // Fill, overflow, push+pop while full, drain with wrap.
    for (int i = 0; i < DEPTH; i++) cycle(1, 32'h1000 + i * 4, 0, 0, "f.fill");
    cycle(1, 32'h2000, 0, 0, "f.over");
    chk("f.of", {31'b0, errOverflow}, 32'd1);
    cycle(1, 32'h3000, 1, 32'h1000, "f.pushpop");
    chk("f.pushpop.ready", {31'b0, predReady}, 32'd0);
    cycle(0, 0, 1, 32'h1004, "f.drain1");
    cycle(0, 0, 1, 32'h1008, "f.drain2");
    cycle(0, 0, 1, 32'h100c, "f.drain3");
    cycle(0, 0, 1, 32'h3000, "f.drain4");

    // Underflow is sticky and produces no pulse.
    cycle(0, 0, 1, 32'h42, "u.res");
    chk("u.uf", {31'b0, errUnderflow}, 32'd1);
    cycle(0, 0, 0, 0, "u.hold");

    // Mismatch with simultaneous push.
    cycle(1, 32'h700, 0, 0, "s.push");
    cycle(1, 32'h400, 1, 32'h704, "s.mispush");
    chk("s.empty", {31'b0, qEmpty}, 32'd1);
    cycle(0, 0, 0, 0, "s.flush");

    // Async reset with two entries queued.
    cycle(1, 32'h10, 0, 0, "r.push1");
    cycle(1, 32'h20, 0, 0, "r.push2");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("r.q");
    #1 rst = 1'b0;

    // Async reset mid-FLUSH while pulses are high.
    cycle(1, 32'h30, 0, 0, "r2.push1");
    cycle(1, 32'h40, 0, 0, "r2.push2");
    cycle(1, 32'h50, 0, 0, "r2.push3");
    cycle(0, 0, 1, 32'h99, "r2.mis");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("r2.async");
    #1 rst = 1'b0;
    cycle(0, 0, 0, 0, "r2.after");

    // Randomized traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      p = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 45);
      if (mq.size() > 0 && $urandom_range(0, 99) < 85) v = mq[0];
      else v = $urandom;
      cycle(p, $urandom, r, v, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
